// File: rtl/usadd_accum_if.sv
// rtl/usadd_accum_if.sv - stream/status bundle between the uSADD parallel counter and its accumulator
interface usadd_accum_if #(
  parameter int CNT_W  = 4,
  parameter int ONES_W = 9
);
  logic              en;
  logic              clr;
  logic [CNT_W-1:0]  cnt;
  logic              out;
  logic              out_valid;
  logic [ONES_W-1:0] ones_cnt;
  logic              done;
  logic              err;

  modport master (
    output en, clr, cnt,
    input  out, out_valid, ones_cnt, done, err
  );

  modport slave (
    input  en, clr, cnt,
    output out, out_valid, ones_cnt, done, err
  );
endinterface

// File: rtl/usadd_accum.sv
// rtl/usadd_accum.sv - modulo-NUM_IN popcount accumulator emitting the scaled-add bitstream
// Also counts emitted ones per fixed-length stream and pulses done on the last bit.
module usadd_accum #(
  parameter int NUM_IN     = 15,
  parameter int CNT_W      = 4,
  parameter int STREAM_LEN = 256,
  parameter int ONES_W     = 9
) (
  input logic           clk,
  input logic           rst,
  usadd_accum_if.slave  bus
);
  localparam int ACC_W = $clog2(2 * NUM_IN);
  localparam int CYC_W = $clog2(STREAM_LEN);
  localparam logic [CNT_W-1:0] NUM_IN_CNT = CNT_W'(NUM_IN);
  localparam logic [ACC_W-1:0] NUM_IN_ACC = ACC_W'(NUM_IN);
  localparam logic [CYC_W-1:0] LAST_CYC   = CYC_W'(STREAM_LEN - 1);

  typedef enum logic {RUN = 1'b0, DONE = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [ONES_W-1:0] ones_q, ones_d;
  logic              out_q, out_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic             over, accept, hit, last;
  logic [ACC_W-1:0] clamp, sum;

  // acc < NUM_IN and clamp <= NUM_IN, so sum < 2*NUM_IN fits ACC_W without wrap
  always_comb begin
    over   = bus.cnt > NUM_IN_CNT;
    accept = bus.en & ~bus.clr;
    clamp  = over ? NUM_IN_ACC : ACC_W'(bus.cnt);
    sum    = acc_q + clamp;
    hit    = sum >= NUM_IN_ACC;
    last   = cyc_q == LAST_CYC;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      acc_q   <= '0;
      cyc_q   <= '0;
      ones_q  <= '0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cyc_q   <= cyc_d;
      ones_q  <= ones_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // An accept in DONE sees cyc_q == 0, so it restarts the stream like any RUN accept
  always_comb begin
    state_d = state_q;
    if (bus.clr) begin
      state_d = RUN;
    end else if (accept) begin
      state_d = last ? DONE : RUN;
    end
  end

  always_comb begin
    acc_d   = acc_q;
    cyc_d   = cyc_q;
    ones_d  = ones_q;
    out_d   = out_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q | (accept & over);
    if (bus.clr) begin
      acc_d  = '0;
      cyc_d  = '0;
      ones_d = '0;
    end else if (accept) begin
      out_d   = hit;
      valid_d = 1'b1;
      acc_d   = hit ? (sum - NUM_IN_ACC) : sum;
      ones_d  = (state_q == DONE) ? ONES_W'(hit) : (ones_q + ONES_W'(hit));
      if (last) begin
        done_d = 1'b1;
        cyc_d  = '0;
        acc_d  = '0;
      end else begin
        cyc_d = cyc_q + 1'b1;
      end
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = valid_q;
  assign bus.ones_cnt  = ones_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_usadd_accum.sv
// tb/tb_usadd_accum.sv - self-checking bench for usadd_accum against a running-sum reference model
module tb_usadd_accum;
  localparam int N   = 15;
  localparam int LEN = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  usadd_accum_if #(.CNT_W(5), .ONES_W(5)) bus ();

  usadd_accum #(
    .NUM_IN(N), .CNT_W(5), .STREAM_LEN(LEN), .ONES_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Model: out is 1 exactly when floor(stream_sum / N) steps up; ones = floor(stream_sum / N)
  int   m_sum, m_pos;
  bit   m_ended;
  logic e_out, e_valid, e_done, e_err;
  logic [4:0] e_ones;

  function automatic logic [8:0] exp_vec();
    return {e_out, e_valid, e_ones, e_done, e_err};
  endfunction

  function automatic logic [8:0] got_vec();
    return {bus.out, bus.out_valid, bus.ones_cnt, bus.done, bus.err};
  endfunction

  task automatic step(input logic r, input logic e, input logic c, input logic [4:0] k);
    int cl, prev;
    rst = r; bus.en = e; bus.clr = c; bus.cnt = k;
    @(posedge clk);
    #1;
    if (r) begin
      m_sum = 0; m_pos = 0; m_ended = 0;
      e_out = 0; e_valid = 0; e_ones = 0; e_done = 0; e_err = 0;
    end else if (c) begin
      m_sum = 0; m_pos = 0; m_ended = 0;
      e_valid = 0; e_done = 0; e_ones = 0;
    end else if (e) begin
      if (int'(k) > N) e_err = 1;
      cl = (int'(k) > N) ? N : int'(k);
      if (m_ended) begin
        m_sum = 0; m_pos = 0; m_ended = 0;
      end
      prev    = m_sum / N;
      m_sum  += cl;
      m_pos  += 1;
      e_out   = (m_sum / N) != prev;
      e_ones  = 5'(m_sum / N);
      e_valid = 1;
      e_done  = (m_pos == LEN);
      if (e_done) m_ended = 1;
    end else begin
      e_valid = 0; e_done = 0;
    end
  endtask

  task automatic test_reset();
    step(1, 1, 0, 5'd15);
    step(1, 1, 0, 5'd15);
    checks++;
    if (got_vec() !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=%b", got_vec(), 9'd0);
    end
    step(0, 1, 0, 5'd15);
    checks++;
    if ({bus.out, bus.out_valid} !== 2'b11 || got_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_first_accept got=%b want=%b", got_vec(), exp_vec());
    end
  endtask

  task automatic run_stream(input string name, input logic [4:0] k, input int want_ones,
                            input int cycles, input bit toggle_en);
    int dones;
    dones = 0;
    for (int i = 0; i < cycles; i++) begin
      step(0, toggle_en ? ~i[0] : 1'b1, 0, k);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL %s cyc%0d got=%b want=%b", name, i, got_vec(), exp_vec());
      end
      if (bus.done) begin
        dones++;
        checks++;
        if (int'(bus.ones_cnt) !== want_ones) begin
          errors++;
          $display("FAIL %s_ones_at_done got=%0d want=%0d", name, bus.ones_cnt, want_ones);
        end
      end
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL %s_done_pulses got=%0d want=1", name, dones);
    end
  endtask

  task automatic test_full_ones();
    step(0, 1, 1, 5'd0);
    run_stream("full_ones", 5'd15, 16, LEN, 0);
  endtask

  task automatic test_back_to_back();
    run_stream("cnt5_a", 5'd5, 5, LEN, 0);
    run_stream("cnt5_b", 5'd5, 5, LEN, 0);
  endtask

  task automatic test_en_gaps();
    logic held;
    step(0, 1, 1, 5'd0);
    run_stream("en_gaps", 5'd7, 7, 2 * LEN, 1);
    held = bus.out;
    step(0, 0, 0, 5'd15);
    checks++;
    if (bus.out !== held || bus.out_valid !== 1'b0 || bus.ones_cnt !== 5'd7) begin
      errors++;
      $display("FAIL en_gap_hold got=%b/%b/%0d want=%b/0/7", bus.out, bus.out_valid, bus.ones_cnt, held);
    end
  endtask

  task automatic test_clr();
    for (int i = 0; i < 6; i++) step(0, 1, 0, 5'd10);
    step(0, 1, 1, 5'd15);
    checks++;
    if (bus.ones_cnt !== 5'd0 || bus.out_valid !== 1'b0 || got_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL clr_discard got=%b want=%b", got_vec(), exp_vec());
    end
    run_stream("after_clr", 5'd3, 3, LEN, 0);
  endtask

  task automatic test_err();
    step(0, 1, 1, 5'd0);
    step(0, 1, 0, 5'd4);
    step(0, 1, 0, 5'd20);
    checks++;
    if (bus.err !== 1'b1 || bus.out !== 1'b1 || got_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL err_clamp got=%b want=%b", got_vec(), exp_vec());
    end
    step(0, 1, 0, 5'd11);
    checks++;
    if (bus.out !== 1'b1 || got_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL err_acc_kept got=%b want=%b", got_vec(), exp_vec());
    end
    step(0, 0, 1, 5'd0);
    checks++;
    if (bus.err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky_clr got=%b want=1", bus.err);
    end
    step(1, 0, 0, 5'd0);
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL err_cleared_rst got=%b want=0", bus.err);
    end
  endtask

  task automatic test_random();
    logic r, e, c;
    logic [4:0] k;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 199) == 0);
      c = ($urandom_range(0, 59) == 0);
      e = ($urandom_range(0, 3) != 0);
      k = ($urandom_range(0, 19) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
      step(r, e, c, k);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc%0d got=%b want=%b", i, got_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.en = 1'b0;
    bus.clr = 1'b0;
    bus.cnt = '0;
    test_reset();
    test_full_ones();
    test_back_to_back();
    test_en_gaps();
    test_clr();
    test_err();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
